vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator and next generation of the line-only HSYNC block. It derives pixel rate from the system clock via a prescaler and runs horizontal and vertical counters. It produces hsync, vsync, display_time, pixel coordinates and frame/line markers. It feeds the VGA colour/pixel path and supports any mode set by parameters (default 640x480@60 from a 50 MHz clock).

Parameters:
CLK_PER_PIX, 2, system clocks per pixel (>=1)
H_SYNC, 96, hsync pulse width in pixels
H_BP, 48, horizontal back porch in pixels
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch in lines
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level (0 = active-low)
HW, 10, width of horizontal counter/pixel_x (must hold H_TOTAL-1)
VW, 10, width of vertical counter/pixel_y (must hold V_TOTAL-1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  run enable; low freezes all counters and outputs
hsync  output  1  horizontal sync at HS_POL when asserted
vsync  output  1  vertical sync at VS_POL when asserted
display_time  output  1  high while inside active area (H and V)
pixel_en  output  1  one-clock pulse per visible pixel (first clock of each pixel period)
pixel_x  output  HW  column in active area, 0..H_ACTIVE-1; 0 when blanked
pixel_y  output  VW  row in active area, 0..V_ACTIVE-1; 0 when blanked
line_start  output  1  one-clock pulse at first clock of each line (h_count=0)
frame_start  output  1  one-clock pulse at first clock of each frame (h_count=0, v_count=0)

Behaviour:
- Derived: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800); V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (525).
- Segment order per line and frame: sync, back porch, active, front porch; counter 0 = first sync pixel/line.
- Internal counters:
  - prescaler 0..CLK_PER_PIX-1, increments every clock when en=1.
  - tick = (prescaler==CLK_PER_PIX-1).
  - h_count 0..H_TOTAL-1, increments on tick, wraps to 0.
  - v_count 0..V_TOTAL-1, increments on tick when h_count==H_TOTAL-1, wraps to 0 after V_TOTAL-1.
  - With CLK_PER_PIX=1, tick is constant 1.
- Reset (async, any time, mid-line included):
  - All counters = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - display_time, pixel_en, line_start, frame_start = 0; pixel_x, pixel_y = 0.
- All outputs are registered and reflect counter state one clock later (latency 1).
- Decode for counter state (p, h, v):
  - hsync asserted iff h < H_SYNC.
  - vsync asserted iff v < V_SYNC.
  - h_act iff H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE; v_act likewise with V values.
  - display_time = h_act & v_act.
  - pixel_x = h-(H_SYNC+H_BP) when display_time, else 0; pixel_y analogous.
  - pixel_en = display_time & (p==0).
  - line_start = (h==0 & p==0).
  - frame_start = line_start & (v==0).
- First clock edge after reset release: outputs show state (0,0,0), so hsync, vsync, line_start and frame_start all assert.
- en=0: every register holds, so pulse outputs hold their value. The generator is expected to be enabled continuously; en exists for bring-up and for synchronising to external logic.
- Wrap: h and v wrap on the same tick at end of frame; frame_start follows on the next decode.
- No overflow: HW/VW sized by parameter; values outside 0..TOTAL-1 are unreachable.

Test Plan:
- Defaults, release reset, run 2 lines -> hsync low 192 consecutive clocks; period 1600 clocks; display_time stays 0 during lines 0-34.
- Defaults, observe line 35 -> display_time rises 288 clocks after hsync fall, high 1280 clocks; pixel_x steps 0..639 every 2 clocks; pixel_en pulses 640 times; pixel_y=0.
- Defaults, run 1 full frame -> vsync low 3200 clocks; frame period 840000 clocks; frame_start exactly once per frame, coincident with vsync and hsync falling; line_start 525 times per frame; last active line pixel_y=479.
- Reset asserted at h_count=500 mid-line -> outputs return to reset values immediately (async); after release, timing restarts from (0,0) identically to the first test.
- en low for 37 clocks mid-active line -> all outputs frozen; after en high, remaining line length is unchanged (total line = 1600+37 clocks).
- CLK_PER_PIX=1, HS_POL=1, H=8/4/16/4, V=2/2/4/2 -> hsync high 8 clocks, period 32 clocks; pixel_en continuous for 16 clocks per active line; frame period 320 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: prescaled pixel tick, horizontal and
// vertical counters, and a registered decode of sync, blanking, coordinates and markers.
module vga_timing_gen #(
    parameter int CLK_PER_PIX = 2,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int HW          = 10,
    parameter int VW          = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          display_time,
    output logic          pixel_en,
    output logic [HW-1:0] pixel_x,
    output logic [VW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT_BEG = H_SYNC + H_BP;
    localparam int H_ACT_END = H_SYNC + H_BP + H_ACTIVE;
    localparam int V_ACT_BEG = V_SYNC + V_BP;
    localparam int V_ACT_END = V_SYNC + V_BP + V_ACTIVE;
    localparam int PW        = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(CLK_PER_PIX - 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic          HS_ON  = (HS_POL != 0);
    localparam logic          VS_ON  = (VS_POL != 0);

    logic [PW-1:0] p_q, p_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          disp_q, disp_d;
    logic          pen_q, pen_d;
    logic [HW-1:0] px_q, px_d;
    logic [VW-1:0] py_q, py_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    logic          tick;
    logic          h_wrap;
    logic          h_act;
    logic          v_act;
    logic [31:0]   h_ext;
    logic [31:0]   v_ext;

    always_comb begin
        tick   = (p_q == P_LAST);
        h_wrap = (h_q == H_LAST);
        p_d    = tick ? '0 : p_q + PW'(1);
        h_d    = h_q;
        v_d    = v_q;
        if (tick) begin
            h_d = h_wrap ? '0 : h_q + HW'(1);
            if (h_wrap) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end
        end

        // Decode in 32 bits so segment bounds never alias in a narrow counter.
        h_ext   = 32'(h_q);
        v_ext   = 32'(v_q);
        h_act   = (h_ext >= 32'(H_ACT_BEG)) && (h_ext < 32'(H_ACT_END));
        v_act   = (v_ext >= 32'(V_ACT_BEG)) && (v_ext < 32'(V_ACT_END));
        hsync_d = (h_ext < 32'(H_SYNC)) ? HS_ON : ~HS_ON;
        vsync_d = (v_ext < 32'(V_SYNC)) ? VS_ON : ~VS_ON;
        disp_d  = h_act && v_act;
        px_d    = disp_d ? HW'(h_ext - 32'(H_ACT_BEG)) : '0;
        py_d    = disp_d ? VW'(v_ext - 32'(V_ACT_BEG)) : '0;
        pen_d   = disp_d && (p_q == '0);
        ls_d    = (h_q == '0) && (p_q == '0);
        fs_d    = ls_d && (v_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q     <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~HS_ON;
            vsync_q <= ~VS_ON;
            disp_q  <= 1'b0;
            pen_q   <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (en) begin
            p_q     <= p_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            disp_q  <= disp_d;
            pen_q   <= pen_d;
            px_q    <= px_d;
            py_q    <= py_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign display_time = disp_q;
    assign pixel_en     = pen_q;
    assign pixel_x      = px_q;
    assign pixel_y      = py_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;

endmodule
